fifo_read_ctrl: RTL
===================

Name: fifo_read_ctrl

Overview:
Read-side controller for the asynchronous FIFO, running entirely in the read clock domain. It accepts the write pointer (Gray-coded) from the write domain and synchronises it. It generates the RAM read address/read enable, the Gray-coded read pointer returned to the write domain, the empty and almost-empty flags, and the occupancy level. It sits between the consumer and the read port of the dual-port FIFO RAM.

Parameters:
ADDR_WIDTH, 5, RAM address bits (depth = 2**ADDR_WIDTH = 32); pointers are ADDR_WIDTH+1 bits wide.
SYNC_STAGES, 2, flop stages in the wptr_gray synchroniser (legal 2..4).
AE_THRESH, 4, almost_empty asserts when level <= AE_THRESH.

Ports:
clkr  input  1  read-domain clock
resetr  input  1  asynchronous active-high reset, read domain
readEnable_req  input  1  consumer read request
wptr_gray  input  ADDR_WIDTH+1  Gray-coded write pointer from write domain (asynchronous to clkr)
rptr  output  ADDR_WIDTH+1  binary read pointer to RAM (RAM uses low ADDR_WIDTH bits)
readEnable  output  1  RAM read strobe (combinational: readEnable_req & ~empty)
rptr_gray  output  ADDR_WIDTH+1  registered Gray-coded read pointer to write domain
rd_valid  output  1  RAM rd data valid this cycle
empty  output  1  FIFO empty (registered)
almost_empty  output  1  level <= AE_THRESH (registered)
rd_level  output  ADDR_WIDTH+1  words available, 0..2**ADDR_WIDTH (registered)

Behaviour:
- Reset is asynchronous and active-high. Values while resetr is high: rptr=0, rptr_gray=0, all synchroniser flops=0, empty=1, almost_empty=1, rd_level=0, rd_valid=0. Reset applies immediately, even mid-transfer; no pending read survives it.
- Synchroniser: wptr_gray passes through SYNC_STAGES flops on clkr, giving wq_gray. No logic sits between the stages. wq_bin is the Gray-to-binary conversion of wq_gray.
- Read accept: readEnable = readEnable_req & ~empty. On an accepted read:
  - rptr increments by 1 at the clkr edge, modulo 2**(ADDR_WIDTH+1); 63 wraps to 0 with the MSB toggling.
  - rptr_gray <= next_bin ^ (next_bin >> 1) at the same edge.
- Data timing: the RAM registers rd on the edge where readEnable=1. rd_valid is a 1-cycle-delayed copy of readEnable, so rd_valid=1 exactly in the cycle rd holds the new word. Latency from request to data is 1 clkr cycle.
- A request while empty=1 is ignored: rptr and rptr_gray hold, readEnable=0, rd_valid=0 next cycle.
- Empty flag: empty <= (next_gray == wq_gray), evaluated every edge using the post-increment Gray pointer. A read of the last word asserts empty on the same edge that advances the pointer, so back-to-back reads never overrun.
- Empty is pessimistic: a new write becomes visible after SYNC_STAGES+1 clkr edges at most, and only then does empty deassert.
- rd_level <= wq_bin - next_bin, modulo 2**(ADDR_WIDTH+1). Full FIFO gives 32, empty gives 0.
- almost_empty <= (that same difference) <= AE_THRESH.
- Simultaneous read and write-pointer change in one cycle: both are applied; the level reflects the synchronised wptr and the incremented rptr.
- No state machine beyond the pointer and flag registers; all outputs except readEnable are registered.

Optional Feature:
Macro: FIFO_RD_UNDERFLOW_EN.
- Defined: adds output port rd_underflow (1 bit).
  - Sticky; set on any clkr edge with readEnable_req=1 and empty=1.
  - Cleared only by resetr.
  - Reset value 0.
- Not defined: the port and its logic are absent. Underflow requests are silently ignored as described above.

Test Plan:
- Reset: hold resetr=1 with wptr_gray=6'b000011 → empty=1, rd_level=0, rptr=0, rptr_gray=0, rd_valid=0. Asserting resetr asynchronously mid-clock clears the outputs without waiting for an edge.
- Sync latency: after reset, set wptr_gray to gray(3)=6'b000010 and hold → empty=1 for 2 edges, empty=0 and rd_level=3 after the 3rd edge; almost_empty=1 since 3<=4.
- Drain: with wptr=gray(3), assert readEnable_req for 4 cycles → readEnable high for the first 3 only; rptr goes 0→1→2→3; empty=1 on the edge that sets rptr=3; rd_valid pulses 3 cycles, each one cycle after its readEnable.
- Wrap: preload rptr near the top by cycling writes/reads to rptr=62, then set wptr=gray(1) (count 3) → three reads give rptr 63→0→1, with rptr_gray 6'b100000→6'b000000→6'b000001; empty=1 at rptr=1.
- Full level: wptr=gray(32)=6'b110000 with rptr=0 → rd_level=32, almost_empty=0; one read → rd_level=31.
- Underflow (FIFO_RD_UNDERFLOW_EN): readEnable_req=1 while empty → rd_underflow=1 and stays 1 after data arrives; pointers unchanged; cleared only by resetr.

Source files
------------

// File: rtl/fifo_read_ctrl_if.sv
// Read-side bundle of the async FIFO: consumer request, write-pointer crossing,
// RAM read strobe/address and the read-domain status flags.
interface fifo_read_ctrl_if #(parameter int ADDR_WIDTH = 5);
    logic                readEnable_req;
    logic [ADDR_WIDTH:0] wptr_gray;
    logic [ADDR_WIDTH:0] rptr;
    logic                readEnable;
    logic [ADDR_WIDTH:0] rptr_gray;
    logic                rd_valid;
    logic                empty;
    logic                almost_empty;
    logic [ADDR_WIDTH:0] rd_level;

    // master is the read controller, slave is the consumer/RAM/write-domain side
    modport master (
        input  readEnable_req, wptr_gray,
        output rptr, readEnable, rptr_gray, rd_valid, empty, almost_empty, rd_level
    );
    modport slave (
        output readEnable_req, wptr_gray,
        input  rptr, readEnable, rptr_gray, rd_valid, empty, almost_empty, rd_level
    );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Read-domain controller of the async FIFO: wptr synchroniser, read pointer, flags, level.
// Optional sticky underflow output enabled by defining FIFO_RD_UNDERFLOW_EN.
module fifo_read_ctrl #(
    parameter int ADDR_WIDTH  = 5,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 4
) (
    input  logic              clkr,
    input  logic              resetr,
    fifo_read_ctrl_if.master  bus
`ifdef FIFO_RD_UNDERFLOW_EN
    ,
    output logic              rd_underflow
`endif
);

    localparam logic [ADDR_WIDTH:0] AE_LIM = (ADDR_WIDTH + 1)'(AE_THRESH);

    logic [ADDR_WIDTH:0] sync_q [SYNC_STAGES];
    logic [ADDR_WIDTH:0] wq_gray;
    logic [ADDR_WIDTH:0] wq_bin;
    logic [ADDR_WIDTH:0] rptr_q;
    logic [ADDR_WIDTH:0] rptr_gray_q;
    logic [ADDR_WIDTH:0] next_bin;
    logic [ADDR_WIDTH:0] next_gray;
    logic [ADDR_WIDTH:0] next_level;
    logic [ADDR_WIDTH:0] level_q;
    logic                empty_q;
    logic                almost_empty_q;
    logic                rd_valid_q;
    logic                rd_accept;

    // Plain flop chain: no logic between stages so each bit resolves independently
    always_ff @(posedge clkr or posedge resetr) begin
        if (resetr) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= bus.wptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign wq_gray = sync_q[SYNC_STAGES-1];

    always_comb begin
        wq_bin = '0;
        for (int i = 0; i <= ADDR_WIDTH; i++) wq_bin[i] = ^(wq_gray >> i);
    end

    // Flags are computed from the post-increment pointer so the last read sets empty at once
    assign rd_accept  = bus.readEnable_req & ~empty_q;
    assign next_bin   = rptr_q + {{ADDR_WIDTH{1'b0}}, rd_accept};
    assign next_gray  = next_bin ^ (next_bin >> 1);
    assign next_level = wq_bin - next_bin;

    always_ff @(posedge clkr or posedge resetr) begin
        if (resetr) begin
            rptr_q         <= '0;
            rptr_gray_q    <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            level_q        <= '0;
            rd_valid_q     <= 1'b0;
        end else begin
            rptr_q         <= next_bin;
            rptr_gray_q    <= next_gray;
            empty_q        <= (next_gray == wq_gray);
            almost_empty_q <= (next_level <= AE_LIM);
            level_q        <= next_level;
            rd_valid_q     <= rd_accept;
        end
    end

`ifdef FIFO_RD_UNDERFLOW_EN
    always_ff @(posedge clkr or posedge resetr) begin
        if (resetr)
            rd_underflow <= 1'b0;
        else if (bus.readEnable_req && empty_q)
            rd_underflow <= 1'b1;
    end
`endif

    assign bus.rptr         = rptr_q;
    assign bus.readEnable   = rd_accept;
    assign bus.rptr_gray    = rptr_gray_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.empty        = empty_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.rd_level     = level_q;

endmodule
